// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fetch_unit
// Program-counter and fetch-sequencing stage. Owns the program counter, the
// Start/Ack run handshake, branch/halt/stall sequencing and saturating
// cycle/instruction counters for performance reporting.
//
// Ports:
//   Clk          in   clock, rising edge
//   Reset        in   asynchronous active-low reset
//   Start        in   run request; run begins when Start falls after being high
//   Halt         in   instruction at ProgCtr is a halt
//   Stall        in   downstream busy, freezes the PC this cycle
//   BranchEn     in   instruction at ProgCtr is a taken branch
//   BranchAbs    in   1 = absolute target, 0 = signed PC-relative offset
//   BranchTarget in   [W-1:0] target / offset from register file
//   ProgCtr      out  [PCW-1:0] current fetch address
//   FetchValid   out  instruction at ProgCtr retires this cycle (combinational)
//   Ack          out  run complete
//   CycleCnt     out  [CW-1:0] cycles spent in RUN, including stalls
//   InstCnt      out  [CW-1:0] instructions retired
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int W   = 8,
  parameter int PCW = 10,
  parameter int CW  = 16
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic           Halt,
  input  logic           Stall,
  input  logic           BranchEn,
  input  logic           BranchAbs,
  input  logic [W-1:0]   BranchTarget,
  output logic [PCW-1:0] ProgCtr,
  output logic           FetchValid,
  output logic           Ack,
  output logic [CW-1:0]  CycleCnt,
  output logic [CW-1:0]  InstCnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [PCW-1:0] r_pc;
  logic [PCW-1:0] w_pc_nxt;
  logic [CW-1:0]  r_cyc;
  logic [CW-1:0]  w_cyc_nxt;
  logic [CW-1:0]  r_inst;
  logic [CW-1:0]  w_inst_nxt;
  logic           r_ack;
  logic           w_ack_nxt;

  logic [PCW-1:0] w_pc_inc;
  logic [PCW-1:0] w_pc_rel;
  logic [PCW-1:0] w_pc_abs;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    logic [CW-1:0] res;
    if (v == {CW{1'b1}}) begin
      res = v;
    end else begin
      res = v + {{(CW-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  // PC arithmetic is naturally modulo 2**PCW by truncation to PCW bits.
  assign w_pc_inc = r_pc + {{(PCW-1){1'b0}}, 1'b1};
  assign w_pc_rel = r_pc + {{(PCW-W){BranchTarget[W-1]}}, BranchTarget};
  assign w_pc_abs = {BranchTarget, {(PCW-W){1'b0}}};

  // Next-state, next-PC and next-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cyc_nxt   = r_cyc;
    w_inst_nxt  = r_inst;
    case (r_state)
      ST_IDLE: begin
        w_pc_nxt   = {PCW{1'b0}};
        w_cyc_nxt  = {CW{1'b0}};
        w_inst_nxt = {CW{1'b0}};
        if (Start) begin
          w_state_nxt = ST_ARMED;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ARMED: begin
        w_pc_nxt   = {PCW{1'b0}};
        w_cyc_nxt  = {CW{1'b0}};
        w_inst_nxt = {CW{1'b0}};
        if (!Start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_RUN: begin
        // Abort outranks stall and halt; state clears on the way to ARMED.
        if (Start) begin
          w_state_nxt = ST_ARMED;
          w_pc_nxt    = {PCW{1'b0}};
          w_cyc_nxt   = {CW{1'b0}};
          w_inst_nxt  = {CW{1'b0}};
        end else if (Stall) begin
          w_cyc_nxt = sat_inc(r_cyc);
        end else begin
          w_cyc_nxt  = sat_inc(r_cyc);
          w_inst_nxt = sat_inc(r_inst);
          if (Halt) begin
            w_state_nxt = ST_DONE;
          end else if (BranchEn) begin
            if (BranchAbs) begin
              w_pc_nxt = w_pc_abs;
            end else begin
              w_pc_nxt = w_pc_rel;
            end
          end else begin
            w_pc_nxt = w_pc_inc;
          end
        end
      end
      ST_DONE: begin
        if (Start) begin
          w_state_nxt = ST_ARMED;
          w_pc_nxt    = {PCW{1'b0}};
          w_cyc_nxt   = {CW{1'b0}};
          w_inst_nxt  = {CW{1'b0}};
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_pc_nxt    = {PCW{1'b0}};
        w_cyc_nxt   = {CW{1'b0}};
        w_inst_nxt  = {CW{1'b0}};
      end
    endcase
    w_ack_nxt = (w_state_nxt == ST_DONE);
  end

  // State, PC, counter and Ack registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
      r_pc    <= {PCW{1'b0}};
      r_cyc   <= {CW{1'b0}};
      r_inst  <= {CW{1'b0}};
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cyc   <= w_cyc_nxt;
      r_inst  <= w_inst_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  assign ProgCtr    = r_pc;
  assign Ack        = r_ack;
  assign CycleCnt   = r_cyc;
  assign InstCnt    = r_inst;
  assign FetchValid = (r_state == ST_RUN) && !Stall;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and fetch-sequencing stage sitting directly upstream of the register file and instruction decode. It owns the program counter, the Start/Ack run handshake with the testbench, and branch/halt/stall sequencing. Branch targets come from the register file's target-register read port. It also keeps saturating cycle and instruction counters for performance reporting.

## Interface
Parameters:
- W, 8, data path width; width of the branch target/offset input
- PCW, 10, program counter width; instruction memory depth is 2**PCW
- CW, 16, width of the performance counters

Ports:
- Clk  input  1  clock; all state updates on the rising edge
- Reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- Start  input  1  run request; the run begins on the first cycle Start is low after it has been seen high
- Halt  input  1  decoder flag: the instruction at ProgCtr is a halt
- Stall  input  1  downstream busy; freezes the PC this cycle
- BranchEn  input  1  decoder flag: the instruction at ProgCtr is a taken branch
- BranchAbs  input  1  1 = absolute target, 0 = PC-relative signed offset
- BranchTarget  input  W  value read from the register file target port
- ProgCtr  output  PCW  current fetch address
- FetchValid  output  1  high in RUN when not stalled; the instruction at ProgCtr retires this cycle
- Ack  output  1  run complete
- CycleCnt  output  CW  cycles spent in RUN, including stalls
- InstCnt  output  CW  instructions retired

## Operation
- States: IDLE, ARMED, RUN, DONE.
- IDLE:
  - ProgCtr = 0; counters held at 0; Ack = 0.
  - Start = 1 -> ARMED.
- ARMED:
  - Outputs same as IDLE.
  - Start = 0 -> RUN; otherwise remain in ARMED.
- RUN, evaluated each cycle in priority order:
  - Stall = 1: ProgCtr holds; FetchValid = 0; Halt and BranchEn ignored; CycleCnt increments.
  - Else Halt = 1: -> DONE; ProgCtr holds; InstCnt and CycleCnt increment (the halt retires).
  - Else BranchEn = 1:
    - BranchAbs = 1: ProgCtr <= {BranchTarget, (PCW-W) zero bits}.
    - BranchAbs = 0: ProgCtr <= ProgCtr + sign-extend(BranchTarget).
  - Else ProgCtr <= ProgCtr + 1.
  - In every non-stalled RUN cycle, InstCnt and CycleCnt both increment.
- Start = 1 seen in RUN aborts the run -> ARMED; ProgCtr and counters clear on the next edge.
- DONE:
  - Ack = 1; ProgCtr, CycleCnt and InstCnt hold final values.
  - Start = 1 -> ARMED; counters and ProgCtr clear.
- Arithmetic:
  - PC arithmetic is modulo 2**PCW: 2**PCW-1 + 1 wraps to 0; relative offsets wrap both directions.
  - Counters saturate at all-ones and never wrap.
- FetchValid is combinational: (state == RUN) && !Stall.
- All other outputs are registered.

## Timing
- Reset low: state = IDLE, ProgCtr = 0, Ack = 0, CycleCnt = 0, InstCnt = 0, effective immediately (asynchronous), including mid-run.
- Reset release: first active edge evaluates IDLE.
- Start high for one cycle, then low: ARMED next edge, RUN the edge after; first fetch at ProgCtr = 0 in the first RUN cycle.
- Branch/increment latency: new ProgCtr is visible the cycle after the branch/instruction cycle; no delay slots.
- Halt: Ack rises on the edge that ends the halt cycle.
- Stall and Halt in the same cycle: stall wins; the halt is re-evaluated next cycle.
- Stall and BranchEn in the same cycle: stall wins; BranchTarget must be held by upstream until the stall clears.
- Start and Halt in the same RUN cycle: Start wins (abort -> ARMED).

## Test plan
- Reset low mid-run at ProgCtr = 37 -> all outputs 0 asynchronously, before the next Clk edge; Start pulse after release -> run starts at 0.
- Start pulse, 5 plain cycles, then Halt -> ProgCtr sequence 0..5; Ack = 1; InstCnt = 6; CycleCnt = 6; values hold in DONE.
- At ProgCtr = 4:
  - BranchEn, BranchAbs = 0, BranchTarget = 8'hFE -> ProgCtr = 2.
  - At ProgCtr = 2: BranchAbs = 1, BranchTarget = 8'h10 -> ProgCtr = 64.
- ProgCtr = 1023, plain cycle -> 0. ProgCtr = 1, relative 8'h80 -> 897.
- Stall held 3 cycles with Halt and BranchEn asserted -> ProgCtr frozen; CycleCnt +3; InstCnt +0. Stall drops with Halt still high -> DONE.
- Counters forced near 16'hFFFF (long run) -> both saturate at 16'hFFFF. Start in DONE -> counters 0 and ProgCtr 0 after two edges.
